// File: rtl/cpu_defs.sv
// Shared opcode constants, ALU operation encodings and the ID/EX control bundle.
// The field order of ctrl_t is the bit order of the registered control outputs.
package cpu_defs;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_BNE  = 6'h05;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b100
    } aluop_e;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        logic   regdst;
        logic   branch;
        logic   branchne;
        logic   jump;
        aluop_e aluop;
    } ctrl_t;

    // Contents of the ID/EX slot; an all-zero value is a bubble.
    typedef struct packed {
        logic       valid;
        logic       nop;
        ctrl_t      ctrl;
        logic [4:0] rt;
    } idex_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'('0);
    localparam idex_t IDEX_BUBBLE = idex_t'('0);

endpackage

// File: rtl/opcode_decoder.sv
// Purely combinational main decoder: opcode -> control bundle, plus illegal
// and "reads rt as a source" flags used by the hazard check.
module opcode_decoder
    import cpu_defs::*;
#(
    parameter bit EXT_OPS = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        is_nop,
    output logic        uses_rt
);

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        uses_rt = 1'b0;
        is_nop  = (instr == 32'd0);
        case (instr[31:26])
            OP_R: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.aluop    = ALU_FUNCT;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_ADD;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_ADD;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALU_SUB;
                uses_rt     = 1'b1;
            end
            OP_J: ctrl.jump = 1'b1;
            OP_ADDI, OP_ORI, OP_SLTI: begin
                if (EXT_OPS) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.aluop    = (instr[31:26] == OP_ORI)  ? ALU_OR  :
                                    (instr[31:26] == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_BNE: begin
                if (EXT_OPS) begin
                    ctrl.branchne = 1'b1;
                    ctrl.aluop    = ALU_SUB;
                    uses_rt       = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // The all-zero word is an R-type encoding but must never write $0.
        if (is_nop) ctrl = CTRL_NONE;
    end

endmodule

// File: rtl/decode_stage_ctrl.sv
// ID-stage control: decodes the IF/ID instruction, detects load-use hazards,
// applies flush > stall > decode priority and holds the ID/EX control register.
module decode_stage_ctrl
    import cpu_defs::*;
#(
    parameter bit EXT_OPS = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             instr_valid_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic             ex_nop_o,
    output logic             ex_regwrite_o,
    output logic             ex_memread_o,
    output logic             ex_memwrite_o,
    output logic             ex_memtoreg_o,
    output logic             ex_alusrc_o,
    output logic             ex_regdst_o,
    output logic             ex_branch_o,
    output logic             ex_branchne_o,
    output logic             ex_jump_o,
    output logic [2:0]       ex_aluop_o,
    output logic [4:0]       ex_rt_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic             dec_nop;
    logic             dec_uses_rt;
    idex_t            idex_q;
    idex_t            idex_d;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             hazard;
    logic             accept;

    opcode_decoder #(.EXT_OPS(EXT_OPS)) u_dec (
        .instr   (instr_i),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .is_nop  (dec_nop),
        .uses_rt (dec_uses_rt)
    );

    assign id_rs = instr_i[25:21];
    assign id_rt = instr_i[20:16];

    // A load into $0 never produces a value worth waiting for.
    assign hazard = idex_q.ctrl.memread && (idex_q.rt != 5'd0) &&
                    ((idex_q.rt == id_rs) || (dec_uses_rt && (idex_q.rt == id_rt)));

    assign stall_o = instr_valid_i && !flush_i && hazard;
    assign accept  = instr_valid_i && !flush_i && !hazard;

    always_comb begin
        idex_d = IDEX_BUBBLE;
        if (accept && !dec_illegal) begin
            idex_d.valid = 1'b1;
            idex_d.nop   = dec_nop;
            idex_d.ctrl  = dec_ctrl;
            idex_d.rt    = id_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q    <= IDEX_BUBBLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            idex_q <= idex_d;
            if (accept && dec_illegal) illegal_q <= 1'b1;
            if (stall_o && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ex_valid_o    = idex_q.valid;
    assign ex_nop_o      = idex_q.nop;
    assign ex_regwrite_o = idex_q.ctrl.regwrite;
    assign ex_memread_o  = idex_q.ctrl.memread;
    assign ex_memwrite_o = idex_q.ctrl.memwrite;
    assign ex_memtoreg_o = idex_q.ctrl.memtoreg;
    assign ex_alusrc_o   = idex_q.ctrl.alusrc;
    assign ex_regdst_o   = idex_q.ctrl.regdst;
    assign ex_branch_o   = idex_q.ctrl.branch;
    assign ex_branchne_o = idex_q.ctrl.branchne;
    assign ex_jump_o     = idex_q.ctrl.jump;
    assign ex_aluop_o    = idex_q.ctrl.aluop;
    assign ex_rt_o       = idex_q.rt;
    assign illegal_o     = illegal_q;
    assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Scoreboard bench: two instances (extended ops on/off, wide/narrow stall counter)
// share stimulus; a reference model pushes expectations, a monitor pops and compares.
module tb_decode_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;

    always #5 clk = ~clk;

    // Instance 1: EXT_OPS=1, CNT_W=16.  Instance 0: EXT_OPS=0, CNT_W=3.
    logic        st1, v1, n1, rw1, mr1, mw1, mtr1, as1, rd1, br1, bn1, j1, ill1;
    logic [2:0]  alu1;
    logic [4:0]  rt1;
    logic [15:0] cnt1;
    logic        st0, v0, n0, rw0, mr0, mw0, mtr0, as0, rd0, br0, bn0, j0, ill0;
    logic [2:0]  alu0;
    logic [4:0]  rt0;
    logic [2:0]  cnt0;

    decode_stage_ctrl #(.EXT_OPS(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
        .stall_o(st1), .ex_valid_o(v1), .ex_nop_o(n1), .ex_regwrite_o(rw1),
        .ex_memread_o(mr1), .ex_memwrite_o(mw1), .ex_memtoreg_o(mtr1), .ex_alusrc_o(as1),
        .ex_regdst_o(rd1), .ex_branch_o(br1), .ex_branchne_o(bn1), .ex_jump_o(j1),
        .ex_aluop_o(alu1), .ex_rt_o(rt1), .illegal_o(ill1), .stall_cnt_o(cnt1));

    decode_stage_ctrl #(.EXT_OPS(1'b0), .CNT_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
        .stall_o(st0), .ex_valid_o(v0), .ex_nop_o(n0), .ex_regwrite_o(rw0),
        .ex_memread_o(mr0), .ex_memwrite_o(mw0), .ex_memtoreg_o(mtr0), .ex_alusrc_o(as0),
        .ex_regdst_o(rd0), .ex_branch_o(br0), .ex_branchne_o(bn0), .ex_jump_o(j0),
        .ex_aluop_o(alu0), .ex_rt_o(rt0), .illegal_o(ill0), .stall_cnt_o(cnt0));

    // {valid, nop, regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, branchne, jump, aluop, rt}
    wire [18:0] ctl1 = {v1, n1, rw1, mr1, mw1, mtr1, as1, rd1, br1, bn1, j1, alu1, rt1};
    wire [18:0] ctl0 = {v0, n0, rw0, mr0, mw0, mtr0, as0, rd0, br0, bn0, j0, alu0, rt0};

    typedef struct packed {
        logic        st;
        logic [18:0] ctl;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, index = EXT_OPS of the instance.
    logic [18:0] m_ctl [2];
    logic        m_ill [2];
    int          m_cnt [2];
    logic        last_stall1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Opcode table: returns {regwrite..jump (9 bits), aluop (3 bits)}.
    function automatic logic [11:0] tbl(input logic [5:0] op, input bit ext,
                                         output bit known, output bit reads_rt);
        known = 1'b1;
        reads_rt = 1'b0;
        tbl = 12'd0;
        case (op)
            6'h00: begin tbl = {9'b100001000, 3'b010}; reads_rt = 1'b1; end
            6'h23: tbl = {9'b110110000, 3'b000};
            6'h2B: begin tbl = {9'b001010000, 3'b000}; reads_rt = 1'b1; end
            6'h04: begin tbl = {9'b000000100, 3'b001}; reads_rt = 1'b1; end
            6'h02: tbl = {9'b000000001, 3'b000};
            6'h08: if (ext) tbl = {9'b100010000, 3'b000}; else known = 1'b0;
            6'h0D: if (ext) tbl = {9'b100010000, 3'b011}; else known = 1'b0;
            6'h0A: if (ext) tbl = {9'b100010000, 3'b100}; else known = 1'b0;
            6'h05: if (ext) begin tbl = {9'b000000010, 3'b001}; reads_rt = 1'b1; end
                   else known = 1'b0;
            default: known = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ctl[k] = 19'd0;
            m_ill[k] = 1'b0;
            m_cnt[k] = 0;
        end
        last_stall1 = 1'b0;
    endtask

    task automatic model_step(input int k, output exp_t e);
        logic [11:0] c;
        bit          known, reads_rt;
        logic        hz, st;
        logic [4:0]  rs, rt, prev_rt;
        int          cmax;
        rs = instr[25:21];
        rt = instr[20:16];
        prev_rt = m_ctl[k][4:0];
        cmax = (k == 1) ? 65535 : 7;
        c = tbl(instr[31:26], k == 1, known, reads_rt);
        hz = m_ctl[k][15] && (prev_rt != 0) && (prev_rt == rs || (reads_rt && prev_rt == rt));
        st = valid && !flush && hz;
        if (flush || !valid || st) m_ctl[k] = 19'd0;
        else if (!known) begin m_ctl[k] = 19'd0; m_ill[k] = 1'b1; end
        else if (instr == 32'd0) m_ctl[k] = {2'b11, 17'd0};
        else m_ctl[k] = {2'b10, c, rt};
        if (st && m_cnt[k] < cmax) m_cnt[k]++;
        e = '{st: st, ctl: m_ctl[k], ill: m_ill[k], cnt: 16'(m_cnt[k])};
    endtask

    task automatic push_exp();
        exp_t e;
        model_step(0, e);
        q0.push_back(e);
        model_step(1, e);
        q1.push_back(e);
        last_stall1 = e.st;
    endtask

    task automatic cycle(input logic [31:0] ins, input logic v, input logic f);
        @(negedge clk);
        instr = ins;
        valid = v;
        flush = f;
        push_exp();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_st1"}, {31'd0, st1}, 0);
        chk({tag, "_ctl1"}, {13'd0, ctl1}, 0);
        chk({tag, "_ill1"}, {31'd0, ill1}, 0);
        chk({tag, "_cnt1"}, {16'd0, cnt1}, 0);
        chk({tag, "_ctl0"}, {13'd0, ctl0}, 0);
        chk({tag, "_ill0"}, {31'd0, ill0}, 0);
        chk({tag, "_cnt0"}, {29'd0, cnt0}, 0);
    endtask

    // Reset pulse in the middle of a cycle; the same cycle's edge decodes ins.
    task automatic mid_reset(input logic [31:0] ins, input logic v, input logic f);
        @(negedge clk);
        instr = ins;
        valid = v;
        flush = f;
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        #1 rst_n = 1'b1;
        push_exp();
    endtask

    // Monitor: stall sampled late in the cycle, registered outputs just after the edge.
    initial begin
        logic s1, s0, have;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            have = (q1.size() > 0) && (q0.size() > 0);
            s1 = st1;
            s0 = st0;
            @(posedge clk);
            #1;
            if (have) begin
                e = q1.pop_front();
                chk("stall1", {31'd0, s1}, {31'd0, e.st});
                chk("ctl1", {13'd0, ctl1}, {13'd0, e.ctl});
                chk("illegal1", {31'd0, ill1}, {31'd0, e.ill});
                chk("cnt1", {16'd0, cnt1}, {16'd0, e.cnt});
                e = q0.pop_front();
                chk("stall0", {31'd0, s0}, {31'd0, e.st});
                chk("ctl0", {13'd0, ctl0}, {13'd0, e.ctl});
                chk("illegal0", {31'd0, ill0}, {31'd0, e.ill});
                chk("cnt0", {16'd0, 13'd0, cnt0}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] rnd_reg();
        case ($urandom_range(0, 3))
            0: rnd_reg = 5'd0;
            default: rnd_reg = 5'(8 + $urandom_range(0, 2));
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0] op;
        if ($urandom_range(0, 15) == 0) return 32'd0;
        case ($urandom_range(0, 23))
            0, 1, 2, 3:     op = 6'h00;
            4, 5, 6, 7, 8:  op = 6'h23;
            9, 10:          op = 6'h2B;
            11, 12:         op = 6'h04;
            13:             op = 6'h02;
            14, 15:         op = 6'h08;
            16:             op = 6'h0D;
            17:             op = 6'h0A;
            18, 19, 20, 21: op = 6'h05;
            22:             op = 6'h3F;
            default:        op = 6'h11;
        endcase
        return {op, rnd_reg(), rnd_reg(), 16'($urandom)};
    endfunction

    initial begin
        logic [31:0] cur;
        logic        cv;
        model_reset();
        instr = 32'h8C08_0000;
        valid = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        valid = 1'b0;
        rst_n = 1'b1;

        // Reset with LW in ID, then load-use on rs.
        mid_reset(32'h8C08_0000, 1'b1, 1'b0);
        cycle(32'h0109_5020, 1'b1, 1'b0);
        cycle(32'h0109_5020, 1'b1, 1'b0);
        // Flush beats a pending load-use stall.
        cycle(32'h8C08_0000, 1'b1, 1'b0);
        cycle(32'h0109_5020, 1'b1, 1'b1);
        cycle(32'h0000_0000, 1'b0, 1'b0);
        // Load-use through rt of SW and of BNE (BNE only reads rt with EXT_OPS).
        cycle(32'h8C09_0000, 1'b1, 1'b0);
        cycle(32'hAC09_0004, 1'b1, 1'b0);
        cycle(32'h8C09_0000, 1'b1, 1'b0);
        cycle(32'h1409_0003, 1'b1, 1'b0);
        cycle(32'h1409_0003, 1'b1, 1'b0);
        // NOP word and loads into $0.
        cycle(32'h0000_0000, 1'b1, 1'b0);
        cycle(32'h8C00_0000, 1'b1, 1'b0);
        cycle(32'h0000_5020, 1'b1, 1'b0);
        // Extended ops: ADDI/ORI/SLTI (illegal on the EXT_OPS=0 instance).
        cycle(32'h2008_0005, 1'b1, 1'b0);
        cycle(32'h3408_00FF, 1'b1, 1'b0);
        cycle(32'h2808_0001, 1'b1, 1'b0);
        cycle(32'h0800_0010, 1'b1, 1'b0);
        // Illegal opcode, flagged and held through valid instructions.
        mid_reset(32'h8C08_0000, 1'b1, 1'b0);
        cycle(32'hFC00_0000, 1'b1, 1'b1);
        cycle(32'hFC00_0000, 1'b1, 1'b0);
        cycle(32'h1000_0002, 1'b1, 1'b0);
        cycle(32'h0109_5020, 1'b1, 1'b0);
        // Reset during a stall leaves nothing pending.
        cycle(32'h8C08_0000, 1'b1, 1'b0);
        mid_reset(32'h0109_5020, 1'b1, 1'b0);
        cycle(32'h0000_0000, 1'b0, 1'b0);

        cur = 32'd0;
        cv = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!last_stall1) begin
                cur = rnd_instr();
                cv = ($urandom_range(0, 9) != 0);
            end
            if (i % 250 == 249) mid_reset(cur, cv, 1'b0);
            else cycle(cur, cv, ($urandom_range(0, 9) == 0));
        end
        cycle(32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("drain1", q1.size(), 0);
        chk("drain0", q0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_ctrl.md
DECODE_STAGE_CTRL -- requirements
Module: decode_stage_ctrl

Interface
REQ-001 Parameter EXT_OPS, default 1: 1 enables ADDI/ORI/SLTI/BNE decode; 0 treats them as illegal.
REQ-002 Parameter CNT_W, default 16: width of the saturating stall counter.
REQ-003 Clock and reset are decided: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-004 clk  in  1  single rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 instr_i  in  32  instruction held in the IF/ID register.
REQ-007 instr_valid_i  in  1  instr_i is a real instruction, not an empty slot.
REQ-008 flush_i  in  1  taken branch or jump resolved downstream; squash the instruction now in ID.
REQ-009 stall_o  out  1  combinational; hold PC and IF/ID this cycle.
REQ-010 ex_valid_o, ex_nop_o  out  1 each  registered; EX slot holds a real instruction / an all-zero NOP.
REQ-011 ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_alusrc_o, ex_regdst_o, ex_branch_o, ex_branchne_o, ex_jump_o  out  1 each  registered ID/EX control bits.
REQ-012 ex_aluop_o  out  3  registered; 000 add, 001 sub, 010 use funct, 011 or, 100 slt.
REQ-013 ex_rt_o  out  5  registered instr_i[20:16] of the instruction now in EX.
REQ-014 illegal_o  out  1  sticky flag; an unimplemented opcode has been decoded.
REQ-015 stall_cnt_o  out  CNT_W  saturating count of cycles in which stall_o was 1.

Function
REQ-016 Decode SHALL follow this opcode table; unlisted bits are 0.
- R (0x00): regwrite, regdst, aluop=010.
- LW (0x23): regwrite, memread, memtoreg, alusrc, aluop=000.
- SW (0x2B): memwrite, alusrc, aluop=000.
- BEQ (0x04): branch, aluop=001.
- J (0x02): jump.
REQ-017 With EXT_OPS=1, extended opcodes SHALL decode as follows.
- ADDI (0x08): regwrite, alusrc, aluop=000.
- ORI (0x0D): regwrite, alusrc, aluop=011.
- SLTI (0x0A): regwrite, alusrc, aluop=100.
- BNE (0x05): branchne, aluop=001.
REQ-018 instr_i==0 SHALL register all control bits as 0, ex_nop_o=1, ex_valid_o=1, and SHALL NOT assert regwrite.
REQ-019 An unlisted opcode with instr_valid_i=1 SHALL register all control bits as 0 and ex_valid_o=0, and SHALL set illegal_o on the next edge.
REQ-020 Load-use hazard: when ex_memread_o=1, ex_rt_o!=0, and ex_rt_o equals instr_i[25:21], stall_o SHALL be 1.
REQ-021 stall_o SHALL also be 1 when ex_memread_o=1, ex_rt_o!=0, ex_rt_o equals instr_i[20:16], and the ID instruction is R, SW, BEQ or BNE.
REQ-022 stall_o SHALL be 0 whenever instr_valid_i=0 or flush_i=1.
REQ-023 Stall SHALL insert a bubble on the next edge: all control bits 0, ex_valid_o=0, ex_nop_o=0, ex_rt_o=0.
REQ-024 A stall SHALL last exactly one cycle, because the bubble clears ex_memread_o.
REQ-025 flush_i=1 SHALL insert a bubble on the next edge, has priority over stall and decode, and SHALL NOT set illegal_o.
REQ-026 instr_valid_i=0 without flush SHALL insert a bubble.
REQ-027 Latency: controls for an accepted instruction SHALL appear exactly one cycle after it is presented.
REQ-028 stall_cnt_o SHALL increment on each edge where stall_o=1 and hold at 2^CNT_W-1.

Reset
REQ-029 rst_n low SHALL immediately clear every registered output, illegal_o and stall_cnt_o to 0, regardless of clk.
REQ-030 The first edge after rst_n rises SHALL decode normally.
REQ-031 Reset asserted during a stall SHALL leave no pending stall.

Structure
REQ-032 Opcode constants and ALUop encodings SHALL reside in shared package cpu_defs, together with the control-bundle field order.
REQ-033 The combinational decoder SHALL be sub-module opcode_decoder (instr, EXT_OPS in; control bundle and illegal out).
REQ-034 The hazard compare, flush/stall priority and ID/EX registers SHALL reside in decode_stage_ctrl.

Verification
REQ-035 Reset: pulse rst_n low mid-cycle with LW in ID -> all outputs 0 at once; next edge after release registers LW controls.
REQ-036 Load-use: LW $8 (0x8C080000) then ADD rs=8 (0x01095020) -> stall_o=1 for one cycle, bubble in EX, stall_cnt_o=1, ADD controls on the following edge.
REQ-037 Priority: flush_i=1 while the load-use condition holds -> stall_o=0, bubble registered, stall_cnt_o unchanged.
REQ-038 NOP and $0: 0x00000000 -> ex_nop_o=1, ex_regwrite_o=0; LW $0 then ADD rs=0 -> no stall.
REQ-039 Illegal opcode: 0xFC000000 -> controls 0, ex_valid_o=0, illegal_o=1 and held through valid instructions until reset.
REQ-040 EXT_OPS: with EXT_OPS=0, ADDI 0x20080005 -> illegal_o=1; with EXT_OPS=1 -> regwrite=1, alusrc=1, aluop=000.
